// File: rtl/ifu_pkg.sv
// Shared types and constants for the instruction fetch unit.
package ifu_pkg;

    typedef enum logic [1:0] {
        S_BOOT,
        S_RUN,
        S_HALT
    } ifu_state_t;

    localparam logic [15:0] NOP_INSTR  = 16'h0000;
    localparam int          OPCODE_MSB = 15;
    localparam int          OPCODE_LSB = 12;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: load a fetched word, flush to NOP, or drop valid only.
module if_id_reg
    import ifu_pkg::*;
#(
    parameter int ADDR_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              flush_i,
    input  logic              kill_i,
    input  logic [15:0]       instr_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [15:0]       instr_o,
    output logic [ADDR_W-1:0] pc_o,
    output logic [ADDR_W-1:0] pc_plus1_o,
    output logic              valid_o
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    logic [15:0]       instr_q;
    logic [ADDR_W-1:0] pc_q;
    logic [ADDR_W-1:0] pc1_q;
    logic              valid_q;

    // flush wins over load; kill only drops valid so the last word stays visible
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            instr_q <= NOP_INSTR;
            pc_q    <= '0;
            pc1_q   <= '0;
            valid_q <= 1'b0;
        end else if (flush_i) begin
            instr_q <= NOP_INSTR;
            valid_q <= 1'b0;
        end else if (load_i) begin
            instr_q <= instr_i;
            pc_q    <= pc_i;
            pc1_q   <= pc_i + PC_ONE;
            valid_q <= 1'b1;
        end else if (kill_i) begin
            valid_q <= 1'b0;
        end
    end

    assign instr_o    = instr_q;
    assign pc_o       = pc_q;
    assign pc_plus1_o = pc1_q;
    assign valid_o    = valid_q;

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: PC, boot/run/halt FSM and IF/ID capture.
// Define IFU_PERF_CNT_EN to add fetch and stall performance counters.
module instruction_fetch_unit
    import ifu_pkg::*;
#(
    parameter int              ADDR_W      = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int              IMEM_DEPTH  = 8192,
    parameter logic [3:0]      HALT_OPCODE = 4'hF
) (
    input  logic              clk,
    input  logic              rst,
    output logic [ADDR_W-1:0] A_InstrAddress,
    output logic              C_IMRead,
    input  logic [15:0]       D_Instruction,
    input  logic              stall,
    input  logic              redirect_en,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [15:0]       if_id_instr,
    output logic [ADDR_W-1:0] if_id_pc,
    output logic [ADDR_W-1:0] if_id_pc_plus1,
    output logic              if_id_valid,
    output logic              halted,
    output logic              fetch_fault
`ifdef IFU_PERF_CNT_EN
   ,output logic [31:0]       perf_fetch_cnt,
    output logic [31:0]       perf_stall_cnt
`endif
);

    localparam logic [ADDR_W-1:0] PC_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

    ifu_state_t        state_q, state_d;
    logic [ADDR_W-1:0] pc_q, pc_d;
    logic              fault_q, fault_d;
    logic              load, flush, kill;
    logic              oob, is_halt;

    assign oob     = 32'(pc_q) >= IMEM_DEPTH;
    assign is_halt = D_Instruction[OPCODE_MSB:OPCODE_LSB] == HALT_OPCODE;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= S_BOOT;
            pc_q    <= RESET_PC;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
        end
    end

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        load    = 1'b0;
        flush   = 1'b0;
        kill    = 1'b0;
        case (state_q)
            S_BOOT: state_d = S_RUN;
            S_RUN: begin
                if (redirect_en) begin
                    pc_d  = redirect_addr;
                    flush = 1'b1;
                end else if (oob) begin
                    fault_d = 1'b1;
                    kill    = 1'b1;
                    state_d = S_HALT;
                end else if (!stall) begin
                    // a halt word is still captured, but the PC stays on it
                    load = 1'b1;
                    if (is_halt) state_d = S_HALT;
                    else         pc_d    = pc_q + PC_ONE;
                end
            end
            S_HALT:  kill    = 1'b1;
            default: state_d = S_BOOT;
        endcase
    end

    if_id_reg #(.ADDR_W(ADDR_W)) u_if_id (
        .clk        (clk),
        .rst_n      (rst),
        .load_i     (load),
        .flush_i    (flush),
        .kill_i     (kill),
        .instr_i    (D_Instruction),
        .pc_i       (pc_q),
        .instr_o    (if_id_instr),
        .pc_o       (if_id_pc),
        .pc_plus1_o (if_id_pc_plus1),
        .valid_o    (if_id_valid)
    );

    // qualified by rst so the read enable is low while reset is held
    assign A_InstrAddress = pc_q;
    assign C_IMRead       = rst & (state_q != S_HALT);
    assign halted         = state_q == S_HALT;
    assign fetch_fault    = fault_q;

`ifdef IFU_PERF_CNT_EN
    logic [31:0] fetch_cnt_q, stall_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fetch_cnt_q <= '0;
            stall_cnt_q <= '0;
        end else begin
            if (load)
                fetch_cnt_q <= fetch_cnt_q + 32'd1;
            if (state_q == S_RUN && stall && !redirect_en)
                stall_cnt_q <= stall_cnt_q + 32'd1;
        end
    end

    assign perf_fetch_cnt = fetch_cnt_q;
    assign perf_stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Bench for instruction_fetch_unit: directed scenarios plus randomized run against a reference model.
module tb_instruction_fetch_unit;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic [15:0] A_InstrAddress;
    logic        C_IMRead;
    logic [15:0] D_Instruction;
    logic        stall = 1'b0;
    logic        redirect_en = 1'b0;
    logic [15:0] redirect_addr = '0;
    logic [15:0] if_id_instr, if_id_pc, if_id_pc_plus1;
    logic        if_id_valid, halted, fetch_fault;
`ifdef IFU_PERF_CNT_EN
    logic [31:0] perf_fetch_cnt, perf_stall_cnt;
`endif

    logic [15:0] mem [0:65535];
    assign D_Instruction = mem[A_InstrAddress];

    always #5 clk = ~clk;

    instruction_fetch_unit dut (
        .clk            (clk),
        .rst            (rst),
        .A_InstrAddress (A_InstrAddress),
        .C_IMRead       (C_IMRead),
        .D_Instruction  (D_Instruction),
        .stall          (stall),
        .redirect_en    (redirect_en),
        .redirect_addr  (redirect_addr),
        .if_id_instr    (if_id_instr),
        .if_id_pc       (if_id_pc),
        .if_id_pc_plus1 (if_id_pc_plus1),
        .if_id_valid    (if_id_valid),
        .halted         (halted),
        .fetch_fault    (fetch_fault)
`ifdef IFU_PERF_CNT_EN
       ,.perf_fetch_cnt (perf_fetch_cnt),
        .perf_stall_cnt (perf_stall_cnt)
`endif
    );

    int checks = 0;
    int errors = 0;

    // reference model: phase 0 = booting, 1 = fetching, 2 = stopped
    int          m_phase;
    logic [15:0] m_pc, m_instr, m_ipc, m_ipc1;
    logic        m_valid, m_fault;
    int unsigned m_fcnt, m_scnt;

    task automatic model_reset();
        m_phase = 0; m_pc = 16'h0000; m_instr = 16'h0000; m_ipc = 16'h0000;
        m_ipc1 = 16'h0000; m_valid = 1'b0; m_fault = 1'b0; m_fcnt = 0; m_scnt = 0;
    endtask

    // one clock edge; the model consumes the inputs that were present before it
    task automatic cyc();
        logic        ren = redirect_en;
        logic [15:0] ra  = redirect_addr;
        logic        st  = stall;
        @(posedge clk); #1;
        if (m_phase == 0) m_phase = 1;
        else if (m_phase == 1) begin
            if (st && !ren) m_scnt++;
            if (ren) begin
                m_pc = ra; m_valid = 1'b0; m_instr = 16'h0000;
            end else if (m_pc >= 8192) begin
                m_fault = 1'b1; m_valid = 1'b0; m_phase = 2;
            end else if (!st) begin
                m_instr = mem[m_pc]; m_ipc = m_pc; m_ipc1 = m_pc + 16'd1;
                m_valid = 1'b1; m_fcnt++;
                if (m_instr[15:12] == 4'hF) m_phase = 2;
                else m_pc = m_pc + 16'd1;
            end
        end else m_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b0; model_reset(); #2; rst = 1'b1;
    endtask

    task automatic test_reset();
        checks++; if (A_InstrAddress !== 16'h0000) begin errors++; $display("FAIL reset_addr got %h want 0000", A_InstrAddress); end
        checks++; if (C_IMRead !== 1'b0) begin errors++; $display("FAIL reset_imread got %b want 0", C_IMRead); end
        checks++; if ({if_id_instr, if_id_pc, if_id_pc_plus1} !== 48'h0) begin errors++; $display("FAIL reset_ifid got %h %h %h want 0", if_id_instr, if_id_pc, if_id_pc_plus1); end
        checks++; if ({if_id_valid, halted, fetch_fault} !== 3'b000) begin errors++; $display("FAIL reset_flags got %b want 000", {if_id_valid, halted, fetch_fault}); end
    endtask

    task automatic test_boot();
        mem[0] = 16'h1111; mem[1] = 16'h2222; mem[2] = 16'h3333; mem[3] = 16'h4444;
        do_reset();
        cyc();
        checks++; if ({if_id_valid, C_IMRead, A_InstrAddress} !== {2'b01, 16'h0000}) begin errors++; $display("FAIL boot_cycle got v=%b rd=%b a=%h want v=0 rd=1 a=0000", if_id_valid, C_IMRead, A_InstrAddress); end
        cyc();
        checks++; if ({if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid} !== {16'h1111, 16'h0000, 16'h0001, 1'b1}) begin errors++; $display("FAIL first_fetch got %h pc=%h p1=%h v=%b want 1111 0000 0001 1", if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid); end
        cyc();
        checks++; if ({if_id_instr, if_id_pc, A_InstrAddress} !== {16'h2222, 16'h0001, 16'h0002}) begin errors++; $display("FAIL second_fetch got %h pc=%h a=%h want 2222 0001 0002", if_id_instr, if_id_pc, A_InstrAddress); end
    endtask

    task automatic test_stall();
        stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            cyc();
            checks++; if ({if_id_instr, if_id_pc, A_InstrAddress, C_IMRead, if_id_valid} !== {16'h2222, 16'h0001, 16'h0002, 2'b11}) begin errors++; $display("FAIL stall_hold[%0d] got %h pc=%h a=%h rd=%b v=%b want 2222 0001 0002 1 1", i, if_id_instr, if_id_pc, A_InstrAddress, C_IMRead, if_id_valid); end
        end
        stall = 1'b0;
        cyc();
        checks++; if ({if_id_instr, if_id_pc} !== {16'h3333, 16'h0002}) begin errors++; $display("FAIL stall_resume got %h pc=%h want 3333 0002", if_id_instr, if_id_pc); end
    endtask

    task automatic test_redirect();
        mem[16'h0100] = 16'hABCD;
        stall = 1'b1; redirect_en = 1'b1; redirect_addr = 16'h0100;
        cyc();
        stall = 1'b0; redirect_en = 1'b0;
        checks++; if ({if_id_valid, if_id_instr, A_InstrAddress} !== {1'b0, 16'h0000, 16'h0100}) begin errors++; $display("FAIL redirect_flush got v=%b %h a=%h want 0 0000 0100", if_id_valid, if_id_instr, A_InstrAddress); end
        cyc();
        checks++; if ({if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid} !== {16'hABCD, 16'h0100, 16'h0101, 1'b1}) begin errors++; $display("FAIL redirect_target got %h pc=%h p1=%h v=%b want abcd 0100 0101 1", if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid); end
    endtask

    task automatic test_halt();
        for (int i = 0; i < 5; i++) mem[i] = 16'h1000 * (i + 1);
        mem[5] = 16'hF000;
        do_reset();
        for (int i = 0; i < 7; i++) cyc();
        checks++; if ({if_id_instr, if_id_pc, halted, C_IMRead, if_id_valid, A_InstrAddress} !== {16'hF000, 16'h0005, 3'b101, 16'h0005}) begin errors++; $display("FAIL halt_capture got %h pc=%h h=%b rd=%b v=%b a=%h want f000 0005 1 0 1 0005", if_id_instr, if_id_pc, halted, C_IMRead, if_id_valid, A_InstrAddress); end
        redirect_en = 1'b1; redirect_addr = 16'h0040;
        cyc();
        redirect_en = 1'b0;
        checks++; if ({if_id_valid, halted, A_InstrAddress, fetch_fault} !== {2'b01, 16'h0005, 1'b0}) begin errors++; $display("FAIL halt_after got v=%b h=%b a=%h f=%b want 0 1 0005 0", if_id_valid, halted, A_InstrAddress, fetch_fault); end
    endtask

    task automatic test_fault();
        mem[0] = 16'h1111;
        do_reset();
        cyc();
        redirect_en = 1'b1; redirect_addr = 16'd8192;
        cyc();
        redirect_en = 1'b0;
        checks++; if ({A_InstrAddress, fetch_fault, halted, if_id_valid} !== {16'h2000, 3'b000}) begin errors++; $display("FAIL fault_pre got a=%h f=%b h=%b v=%b want 2000 0 0 0", A_InstrAddress, fetch_fault, halted, if_id_valid); end
        cyc();
        checks++; if ({fetch_fault, halted, if_id_valid, C_IMRead} !== 4'b1100) begin errors++; $display("FAIL fault_set got f=%b h=%b v=%b rd=%b want 1 1 0 0", fetch_fault, halted, if_id_valid, C_IMRead); end
        // redirect arriving with a halt word on the bus
        mem[0] = 16'hF123; mem[16'h0020] = 16'h1234;
        do_reset();
        cyc();
        redirect_en = 1'b1; redirect_addr = 16'h0020;
        cyc();
        redirect_en = 1'b0;
        checks++; if ({halted, if_id_valid, C_IMRead, A_InstrAddress} !== {3'b001, 16'h0020}) begin errors++; $display("FAIL redirect_vs_halt got h=%b v=%b rd=%b a=%h want 0 0 1 0020", halted, if_id_valid, C_IMRead, A_InstrAddress); end
        cyc();
        checks++; if ({if_id_instr, if_id_pc, halted} !== {16'h1234, 16'h0020, 1'b0}) begin errors++; $display("FAIL redirect_vs_halt_next got %h pc=%h h=%b want 1234 0020 0", if_id_instr, if_id_pc, halted); end
    endtask

    task automatic test_mid_reset();
        stall = 1'b1; cyc(); cyc(); stall = 1'b0; cyc();
        rst = 1'b0; model_reset(); #2;
        checks++; if ({A_InstrAddress, C_IMRead, if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid, halted, fetch_fault} !== 68'h0) begin errors++; $display("FAIL mid_reset got a=%h rd=%b %h %h %h v=%b h=%b f=%b want all 0", A_InstrAddress, C_IMRead, if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid, halted, fetch_fault); end
`ifdef IFU_PERF_CNT_EN
        checks++; if ({perf_fetch_cnt, perf_stall_cnt} !== 64'h0) begin errors++; $display("FAIL mid_reset_perf got %0d %0d want 0 0", perf_fetch_cnt, perf_stall_cnt); end
`endif
        rst = 1'b1;
    endtask

    task automatic test_random();
        int hold = 0;
        for (int i = 0; i < 8192; i++) begin
            mem[i] = 16'($urandom);
            if ($urandom_range(31) != 0 && mem[i][15:12] == 4'hF) mem[i][15] = 1'b0;
        end
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            stall         = ($urandom_range(3) == 0);
            redirect_en   = ($urandom_range(9) == 0);
            redirect_addr = ($urandom_range(7) == 0) ? 16'($urandom_range(65535, 8192)) : 16'($urandom_range(8191));
            cyc();
            checks++; if ({A_InstrAddress, C_IMRead, halted, fetch_fault} !== {m_pc, m_phase != 2, m_phase == 2, m_fault}) begin errors++; $display("FAIL rand_ctrl[%0d] got a=%h rd=%b h=%b f=%b want %h %b %b %b", n, A_InstrAddress, C_IMRead, halted, fetch_fault, m_pc, m_phase != 2, m_phase == 2, m_fault); end
            checks++; if ({if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid} !== {m_instr, m_ipc, m_ipc1, m_valid}) begin errors++; $display("FAIL rand_ifid[%0d] got %h %h %h %b want %h %h %h %b", n, if_id_instr, if_id_pc, if_id_pc_plus1, if_id_valid, m_instr, m_ipc, m_ipc1, m_valid); end
`ifdef IFU_PERF_CNT_EN
            checks++; if ({perf_fetch_cnt, perf_stall_cnt} !== {m_fcnt, m_scnt}) begin errors++; $display("FAIL rand_perf[%0d] got %0d %0d want %0d %0d", n, perf_fetch_cnt, perf_stall_cnt, m_fcnt, m_scnt); end
`endif
            hold = (m_phase == 2) ? hold + 1 : 0;
            if (hold >= 3 || $urandom_range(199) == 0) begin
                hold = 0;
                stall = 1'b0; redirect_en = 1'b0;
                do_reset();
            end
        end
        stall = 1'b0; redirect_en = 1'b0;
    endtask

    initial begin
        for (int i = 0; i < 65536; i++) mem[i] = 16'h0000;
        model_reset();
        @(posedge clk); #1;
        test_reset();
        test_boot();
        test_stall();
        test_redirect();
        test_halt();
        test_fault();
        test_mid_reset();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
